// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS widths, control tokens, FSM state type and token test.
package tmds_pkg;
  localparam int TMDS_W = 10;
  localparam int DATA_W = 8;
  localparam logic [TMDS_W-1:0] TOK_CD00 = 10'h354;
  localparam logic [TMDS_W-1:0] TOK_CD01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] TOK_CD10 = 10'h154;
  localparam logic [TMDS_W-1:0] TOK_CD11 = 10'h2AB;
  typedef enum logic {SEARCH, LOCKED} state_t;
  function automatic logic is_tok(input logic [TMDS_W-1:0] w);
    return w == TOK_CD00 || w == TOK_CD01 || w == TOK_CD10 || w == TOK_CD11;
  endfunction
endpackage

// File: rtl/tmds_decoder_if.sv
// tmds_decoder_if: deserializer word in, decoded channel data and alignment status out.
interface tmds_decoder_if;
  import tmds_pkg::*;
  logic [TMDS_W-1:0] raw_in;
  logic [DATA_W-1:0] VD;
  logic [1:0] CD;
  logic VDE;
  logic locked;
  logic [3:0] offset;
  logic slip;
  modport master (output raw_in, input VD, CD, VDE, locked, offset, slip);
  modport slave (input raw_in, output VD, CD, VDE, locked, offset, slip);
endinterface

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational 10b TMDS word to token flag, control value and video byte.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_W-1:0] word,
  output logic              is_token,
  output logic [1:0]        cd,
  output logic [DATA_W-1:0] vd
);
  logic [DATA_W-1:0] q;
  assign q = word[9] ? ~word[7:0] : word[7:0];
  assign is_token = is_tok(word);
  assign cd = word == TOK_CD01 ? 2'b01 : word == TOK_CD10 ? 2'b10 : word == TOK_CD11 ? 2'b11 : 2'b00;
  always_comb begin
    vd[0] = q[0];
    for (int i = 1; i < DATA_W; i++) vd[i] = word[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
  end
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: word alignment by control-token hunting, then 2-stage TMDS decode.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4096
) (
  input logic clk,
  input logic rst,
  tmds_decoder_if.slave bus
);
  localparam int TW = $clog2(LOCK_COUNT + 1);
  localparam int NW = $clog2(LOSS_COUNT);
  logic [TMDS_W-1:0] prev_raw, a, a_q;
  logic [TW-1:0] tok_cnt;
  logic [NW-1:0] nc_cnt;
  state_t state;
  logic tok_q, vde_r, lock_r, slip_r;
  logic [1:0] cd_q, cd_r;
  logic [DATA_W-1:0] vd_q, vd_r;
  logic [3:0] off;
  assign a = TMDS_W'({bus.raw_in, prev_raw} >> off);
  tmds_word_decode u_dec (.word(a_q), .is_token(tok_q), .cd(cd_q), .vd(vd_q));
  assign bus.VD = vd_r;
  assign bus.CD = cd_r;
  assign bus.VDE = vde_r;
  assign bus.locked = lock_r;
  assign bus.offset = off;
  assign bus.slip = slip_r;
  // The FSM judges the unregistered word so a slip takes effect on the very next word;
  // the output stage trails by one clock, so it is gated by the state one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_raw <= '0;
      a_q <= '0;
      tok_cnt <= '0;
      nc_cnt <= '0;
      state <= SEARCH;
      off <= '0;
      slip_r <= 1'b0;
      lock_r <= 1'b0;
      vde_r <= 1'b0;
      cd_r <= '0;
      vd_r <= '0;
    end else begin
      prev_raw <= bus.raw_in;
      a_q <= a;
      slip_r <= 1'b0;
      lock_r <= state == LOCKED;
      vde_r <= state == LOCKED && !tok_q;
      cd_r <= (state == LOCKED && tok_q) ? cd_q : '0;
      vd_r <= (state == LOCKED && !tok_q) ? vd_q : '0;
      if (state == SEARCH) begin
        if (is_tok(a)) begin
          tok_cnt <= (tok_cnt == TW'(LOCK_COUNT)) ? tok_cnt : tok_cnt + 1'b1;
          if (tok_cnt >= TW'(LOCK_COUNT - 1)) begin
            state <= LOCKED;
            nc_cnt <= '0;
          end
        end else begin
          tok_cnt <= '0;
          off <= (off == 4'd9) ? 4'd0 : off + 1'b1;
          slip_r <= 1'b1;
        end
      end else if (is_tok(a)) nc_cnt <= '0;
      else if (nc_cnt == NW'(LOSS_COUNT - 1)) begin
        state <= SEARCH;
        tok_cnt <= '0;
      end else nc_cnt <= nc_cnt + 1'b1;
    end
  end
endmodule
